tt_um_uart_tx: RTL and testbench

- Tiny Tapeout user-project top that transmits one byte on a UART line.
- Sends the byte on `ui_in` as an 8N1 or 8E1 frame on a bidirectional pin, in response to a send strobe.
- Drives part of the `uio` bank as outputs, so the bank is turned around from input-only use.
- Also reports busy, done, overrun and a count of frames sent.

---
 rtl/tt_uart_pkg.sv | 22 ++
 rtl/uart_tx_core.sv | 96 +++++++++
 rtl/tt_um_uart_tx.sv | 67 ++++++
 tb/tb_tt_um_uart_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_uart_pkg.sv
// Shared types and pin map for the Tiny Tapeout UART transmitter.
// Frame FSM states, uio bit positions and the uio output-enable mask.
package tt_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int TX   = 0;
  localparam int BUSY = 1;
  localparam int DONE = 2;
  localparam int OVR  = 3;
  localparam int SEND = 4;
  localparam int PAR  = 5;

  localparam logic [7:0] UIO_OE = 8'h0F;

endpackage

// File: rtl/uart_tx_core.sv
// UART frame engine: baud counter, shift register, parity and frame FSM.
// Accepts start only in IDLE; tx, busy and done are all registered.
module uart_tx_core #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       par_en,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  import tt_uart_pkg::*;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      sh;
  logic            par_q;
  logic            par_bit;
  logic            tick;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      sh      <= '0;
      par_q   <= 1'b0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) begin
        cnt <= tick ? '0 : cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            sh      <= data;
            par_q   <= par_en;
            par_bit <= ^data;
            cnt     <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            idx   <= '0;
            tx    <= sh[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (idx == 3'd7) begin
              state <= par_q ? PARITY : STOP;
              tx    <= par_q ? par_bit : 1'b1;
            end else begin
              idx <= idx + 3'd1;
              sh  <= {1'b0, sh[7:1]};
              tx  <= sh[1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            state <= IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tt_um_uart_tx.sv
// Tiny Tapeout top: send synchroniser, edge detect, overrun, frame count.
// uo_out already includes the frame finishing this cycle (done pulse).
module tt_um_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);
  import tt_uart_pkg::*;

  logic       s1, s2, s3;
  logic       send_edge;
  logic       ovr;
  logic [7:0] cnt;
  logic       tx, busy, done;
  logic       unused_ok;

  assign send_edge = s2 & ~s3;
  assign unused_ok = &{1'b0, ena, uio_in[7:6], uio_in[3:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s3  <= 1'b0;
      ovr <= 1'b0;
      cnt <= '0;
    end else begin
      s1  <= uio_in[SEND];
      s2  <= s1;
      s3  <= s2;
      if (send_edge && busy) ovr <= 1'b1;
      cnt <= cnt + {7'd0, done};
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (send_edge & ~busy),
    .data   (ui_in),
    .par_en (uio_in[PAR]),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  assign uo_out = cnt + {7'd0, done};
  assign uio_oe = UIO_OE;

  always_comb begin
    uio_out       = '0;
    uio_out[TX]   = tx;
    uio_out[BUSY] = busy;
    uio_out[DONE] = done;
    uio_out[OVR]  = ovr;
  end

endmodule

// File: tb/tb_tt_um_uart_tx.sv
// Scoreboard bench for tt_um_uart_tx with CLKS_PER_BIT=4.
// Stimulus queues expected frames; a negedge monitor checks them.
module tb_tt_um_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic       tx, busy, done, ovr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [10:0] bits;
    int          nbits;
    logic [7:0]  cnt;
  } frame_t;

  frame_t     exp_q[$];
  frame_t     cur;
  logic [7:0] exp_cnt = 8'h00;
  bit         in_fr = 1'b0;
  int         cyc = 0;

  always #5 clk = ~clk;

  tt_um_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  assign tx   = uio_out[0];
  assign busy = uio_out[1];
  assign done = uio_out[2];
  assign ovr  = uio_out[3];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic frame_t mk(input logic [7:0] d, input logic p,
                                input logic [7:0] c);
    frame_t f;
    f.bits  = p ? {1'b1, ^d, d, 1'b0} : {1'b0, 1'b1, d, 1'b0};
    f.nbits = p ? 11 : 10;
    f.cnt   = c;
    return f;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (uio_oe !== 8'h0F || uio_out[7:4] !== 4'h0 ||
          (busy !== 1'b1 && tx !== 1'b1)) begin
        errors++;
        $display("FAIL pins actual oe=%0h out=%0h required oe=0f hi=0 tx=1 idle",
                 uio_oe, uio_out);
      end
      if (!rst_n) begin
        in_fr = 1'b0;
      end else begin
        if (!in_fr && done) chk("stray_done", {31'd0, done}, 0);
        if (!in_fr && busy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
            cur = mk(8'h00, 1'b0, 8'h00);
          end else begin
            cur = exp_q.pop_front();
          end
          in_fr = 1'b1;
          cyc = 0;
        end
        if (in_fr) begin
          if (busy) begin
            if (cyc % CPB == CPB / 2 && cyc / CPB < cur.nbits)
              chk($sformatf("tx_bit%0d", cyc / CPB), {31'd0, tx},
                  {31'd0, cur.bits[cyc / CPB]});
            cyc++;
            if (cyc > 12 * CPB) begin
              chk("frame_len_overflow", cyc, cur.nbits * CPB);
              in_fr = 1'b0;
            end
          end else begin
            chk("frame_len", cyc, cur.nbits * CPB);
            chk("done_pulse", {31'd0, done}, 1);
            chk("uo_out_frame", {24'd0, uo_out}, {24'd0, cur.cnt});
            in_fr = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic p);
    @(posedge clk);
    #1;
    ui_in     = d;
    uio_in[5] = p;
    uio_in[4] = 1'b1;
    repeat (CPB) @(posedge clk);
    #1;
    uio_in[4] = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (done !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk("done_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    uio_in[4] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = 8'h00;
  endtask

  task automatic frame(input logic [7:0] d, input logic p);
    exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back(mk(d, p, exp_cnt));
    send(d, p);
    wait_done(80);
  endtask

  initial begin
    frame_t f;
    logic [7:0] d;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ovr", {31'd0, ovr}, 0);
    chk("rst_uo_out", {24'd0, uo_out}, 0);
    chk("rst_oe", {24'd0, uio_oe}, 32'h0F);
    rst_n = 1'b1;

    f.bits = 11'h34A; f.nbits = 10; f.cnt = 8'd1;
    exp_cnt = 8'd1;
    exp_q.push_back(f);
    send(8'hA5, 1'b0);
    wait_done(80);

    f.bits = 11'h60E; f.nbits = 11; f.cnt = 8'd2;
    exp_cnt = 8'd2;
    exp_q.push_back(f);
    send(8'h07, 1'b1);
    wait_done(80);
    chk("uo_out_two", {24'd0, uo_out}, 2);
    chk("no_ovr_yet", {31'd0, ovr}, 0);

    do_reset();
    exp_cnt = 8'd1;
    exp_q.push_back(mk(8'h3C, 1'b0, 8'd1));
    send(8'h3C, 1'b0);
    repeat (9) @(posedge clk);
    send(8'hFF, 1'b0);
    @(negedge clk);
    chk("ovr_set", {31'd0, ovr}, 1);
    wait_done(80);
    chk("ovr_one_frame", {24'd0, uo_out}, 1);
    repeat (40) @(negedge clk);
    chk("ovr_no_restart", {31'd0, busy}, 0);
    chk("ovr_sticky", {31'd0, ovr}, 1);
    chk("ovr_cnt_hold", {24'd0, uo_out}, 1);

    exp_q.push_back(mk(8'h5A, 1'b0, 8'd2));
    send(8'h5A, 1'b0);
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_tx", {31'd0, tx}, 1);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_uo_out", {24'd0, uo_out}, 0);
    chk("abort_ovr", {31'd0, ovr}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = 8'h00;
    frame(8'hC3, 1'b1);
    chk("after_abort_cnt", {24'd0, uo_out}, 1);

    do_reset();
    for (int i = 1; i <= 256; i++) begin
      d = 8'(i) ^ 8'h5A;
      frame(d, i[0]);
      if (i == 255) chk("cnt_255", {24'd0, uo_out}, 32'd255);
    end
    chk("cnt_wrap", {24'd0, uo_out}, 0);
    chk("b2b_no_ovr", {31'd0, ovr}, 0);

    repeat (20) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
